// File: rtl/alu_seq.sv
// Sequential Beta-style ALU. Compare, add/sub, boolean and shift finish in one cycle.
// MUL (shift-add) and DIV (restoring) iterate one bit per cycle.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       fn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] opa_reg, opa_next;
  logic [WIDTH-1:0] opb_reg, opb_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic             is_div_reg, is_div_next;

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] add_res;
  logic             flag_z, flag_n, flag_v, cmp_bit;
  logic [WIDTH-1:0] cmp_res;
  logic [WIDTH-1:0] arith_res;
  logic [3:0]       bool_tt;
  logic [WIDTH-1:0] bool_res;
  logic [SHW-1:0]   sh_amt;
  logic [WIDTH-1:0] shift_res;
  logic [WIDTH-1:0] single_res;
  logic             is_iter_op;

  assign add_res = a + b;
  assign sub_res = a + ~b + WIDTH'(1);
  assign flag_z  = (sub_res == '0);
  assign flag_n  = sub_res[WIDTH-1];
  // Signed overflow of a-b: operand signs differ and the result sign differs from a.
  assign flag_v  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    cmp_bit = 1'b0;
    case (fn[2:1])
      2'b01:   cmp_bit = flag_z;
      2'b10:   cmp_bit = flag_n ^ flag_v;
      2'b11:   cmp_bit = flag_z | (flag_n ^ flag_v);
      default: cmp_bit = 1'b0;
    endcase
  end

  assign cmp_res = {{(WIDTH-1){1'b0}}, cmp_bit};

  always_comb begin
    arith_res = '0;
    case (fn[1:0])
      2'b00:   arith_res = add_res;
      2'b01:   arith_res = sub_res;
      default: arith_res = '0;
    endcase
  end

  assign bool_tt = fn[3:0];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bool
      assign bool_res[gi] = bool_tt[{b[gi], a[gi]}];
    end
  endgenerate

  assign sh_amt = b[SHW-1:0];

  always_comb begin
    shift_res = '0;
    case (fn[1:0])
      2'b00:   shift_res = a << sh_amt;
      2'b01:   shift_res = a >> sh_amt;
      2'b11:   shift_res = $signed(a) >>> sh_amt;
      default: shift_res = '0;
    endcase
  end

  always_comb begin
    single_res = '0;
    case (fn[5:4])
      2'b00:   single_res = cmp_res;
      2'b01:   single_res = arith_res;
      2'b10:   single_res = bool_res;
      default: single_res = shift_res;
    endcase
  end

  assign is_iter_op = (fn[5:4] == 2'b01) && fn[1];

  // ---------------- iterative datapath ----------------
  // MUL: acc = partial product, opa = multiplicand (shifts left), opb = multiplier (shifts right).
  // DIV: acc = remainder, opa = dividend shifting out / quotient shifting in, opb = divisor.
  logic [WIDTH-1:0] mul_step;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  assign mul_step  = acc_reg + (opb_reg[0] ? opa_reg : '0);
  assign rem_shift = {acc_reg, opa_reg[WIDTH-1]};
  assign div_ge    = (rem_shift >= {1'b0, opb_reg});
  // When div_ge holds the true difference is below the divisor, so the low bits suffice.
  assign rem_diff  = rem_shift[WIDTH-1:0] - opb_reg;
  assign rem_step  = div_ge ? rem_diff : rem_shift[WIDTH-1:0];
  assign quo_step  = {opa_reg[WIDTH-2:0], div_ge};

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      y_reg      <= '0;
      cnt_reg    <= '0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      acc_reg    <= '0;
      is_div_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      y_reg      <= y_next;
      cnt_reg    <= cnt_next;
      opa_reg    <= opa_next;
      opb_reg    <= opb_next;
      acc_reg    <= acc_next;
      is_div_reg <= is_div_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    y_next      = y_reg;
    cnt_next    = cnt_reg;
    opa_next    = opa_reg;
    opb_next    = opb_reg;
    acc_next    = acc_reg;
    is_div_next = is_div_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (is_iter_op) begin
            opa_next    = a;
            opb_next    = b;
            acc_next    = '0;
            cnt_next    = CW'(WIDTH);
            is_div_next = fn[0];
            state_next  = ITER;
          end else begin
            y_next     = single_res;
            state_next = DONE;
          end
        end
      end
      ITER: begin
        cnt_next = cnt_reg - CW'(1);
        if (is_div_reg) begin
          acc_next = rem_step;
          opa_next = quo_step;
        end else begin
          acc_next = mul_step;
          opa_next = opa_reg << 1;
          opb_next = opb_reg >> 1;
        end
        if (cnt_reg == CW'(1)) begin
          y_next     = is_div_reg ? quo_step : mul_step;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg == ITER);
  assign out_valid = (state_reg == DONE);
  assign y         = y_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32: hand-computed results, latency,
// busy/in_ready behaviour, backpressure and mid-operation reset.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  fn;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fn        (fn),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op with out_ready=1, garbage on the inputs while the op is in flight.
  task automatic do_op(input string tag, input logic [5:0] f, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] exp_y,
                       input int exp_lat, input int exp_busy);
    int wait_cnt;
    int lat;
    int busy_cnt;
    int rdy_cnt;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 100) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check_eq({tag, "_rdy"}, in_ready, 1);
    fn = f; a = va; b = vb; in_valid = 1'b1;
    @(posedge clk); #1;
    fn = 6'b010000; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    lat = 1; busy_cnt = 0; rdy_cnt = 0;
    while (!out_valid && lat < 200) begin
      busy_cnt += int'(busy);
      rdy_cnt  += int'(in_ready);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check_eq({tag, "_y"}, y, exp_y);
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_busy"}, busy_cnt, exp_busy);
    check_eq({tag, "_nordy"}, rdy_cnt, 0);
    $display("txn %-8s fn=%b a=%h b=%h y=%h lat=%0d busy=%0d", tag, f, va, vb, y, lat, busy_cnt);
    @(posedge clk); #1;
    check_eq({tag, "_rel"}, out_valid, 0);
  endtask

  initial begin
    int ov_cnt;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fn = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_y", y, 0);
    check_eq("rst_ov", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_rdy", in_ready, 1);

    do_op("add_ovf", 6'b010000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1, 0);
    do_op("cmplt_v", 6'b000101, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0);
    do_op("cmplt_n", 6'b000101, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1, 0);
    do_op("cmpeq",   6'b000011, 32'h0000_0005, 32'h0000_0005, 32'h0000_0001, 1, 0);
    do_op("cmple",   6'b000111, 32'h0000_0005, 32'h0000_0005, 32'h0000_0001, 1, 0);
    do_op("cmp00",   6'b000001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1, 0);
    do_op("sub",     6'b010001, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1, 0);
    do_op("addwrap", 6'b010000, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1, 0);
    do_op("and",     6'b101000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1, 0);
    do_op("xor",     6'b100110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1, 0);
    do_op("sra",     6'b110011, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1, 0);
    do_op("sh10",    6'b110010, 32'h8000_0000, 32'd31,        32'h0000_0000, 1, 0);
    do_op("shl_amt", 6'b110000, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 1, 0);
    do_op("shr",     6'b110001, 32'h8000_0000, 32'd4,         32'h0800_0000, 1, 0);
    do_op("mul",     6'b010010, 32'h0001_2345, 32'h0001_0000, 32'h2345_0000, 33, 32);
    do_op("mul_max", 6'b010010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 32);
    do_op("div",     6'b010011, 32'd100,       32'd7,         32'd14,        33, 32);
    do_op("div0",    6'b010011, 32'd5,         32'd0,         32'hFFFF_FFFF, 33, 32);

    // Backpressure: result parked in DONE, new request waiting on the inputs.
    out_ready = 1'b0;
    fn = 6'b010000; a = 32'd2; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'd100; b = 32'd100;
    check_eq("bp_first", y, 5);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("bp_hold_y", y, 5);
      check_eq("bp_hold_ov", out_valid, 1);
      check_eq("bp_hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_hs_ov", out_valid, 0);
    check_eq("bp_hs_rdy", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp_next_ov", out_valid, 1);
    check_eq("bp_next_y", y, 200);
    $display("txn bp       held 5 cycles, next accept y=%h", y);
    @(posedge clk); #1;

    // Reset in the middle of a MUL.
    fn = 6'b010010; a = 32'h0001_2345; b = 32'h0001_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_eq("rm_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rm_y", y, 0);
    check_eq("rm_busy0", busy, 0);
    check_eq("rm_ov", out_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ov_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      ov_cnt += int'(out_valid);
    end
    check_eq("rm_no_ov", ov_cnt, 0);
    check_eq("rm_rdy", in_ready, 1);
    $display("txn rst      mid-MUL reset, out_valid count after release=%0d", ov_cnt);
    do_op("add_post", 6'b010000, 32'd2, 32'd3, 32'd5, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
